// File: rtl/vive_pkg.sv
// Shared definitions for the lighthouse emulator: LFSR width, transmitter
// state encoding and the BMC line idle level.
package vive_pkg;

  localparam int unsigned LFSR_WIDTH = 17;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SEEK        = 3'd1,
    FIRST_HALF  = 3'd2,
    SECOND_HALF = 3'd3,
    DONE        = 3'd4
  } tx_state_e;

  localparam logic BMC_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/lfsr_galois_step.sv
// One combinational Galois LFSR step; shared by the transmitter and the offset
// finder so both sides agree on bit order and feedback definition.
module lfsr_galois_step
  import vive_pkg::*;
(
  input  logic [LFSR_WIDTH-1:0] state_i,
  input  logic [LFSR_WIDTH-1:0] polynomial_i,
  output logic [LFSR_WIDTH-1:0] next_state_o,
  output logic                  out_bit_o
);

  // Emit the LSB, shift right and fold in the feedback mask when the LSB is set
  always_comb begin
    out_bit_o = state_i[0];
    if (state_i[0]) begin
      next_state_o = (state_i >> 1) ^ polynomial_i;
    end else begin
      next_state_o = state_i >> 1;
    end
  end

endmodule

// File: rtl/lfsr_bmc_transmitter.sv
// Lighthouse-side emulator: seeks a Galois LFSR to a start offset, then emits
// a programmable number of chips BMC-encoded on a single line.
module lfsr_bmc_transmitter
  import vive_pkg::*;
#(
  parameter int unsigned           HALF_BIT_TICKS = 8,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED      = 17'h00001
) (
  input  logic                  clk_96MHz,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LFSR_WIDTH-1:0] polynomial,
  input  logic [LFSR_WIDTH-1:0] offset,
  input  logic [15:0]           num_bits,
  output logic                  bmc_out,
  output logic                  tx_active,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [7:0] TICK_LAST = 8'(HALF_BIT_TICKS - 1);

  tx_state_e             state_q, state_d;
  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [LFSR_WIDTH-1:0] poly_q, poly_d;
  logic [LFSR_WIDTH-1:0] seek_cnt_q, seek_cnt_d;
  logic [15:0]           num_bits_q, num_bits_d;
  logic [15:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]            tick_q, tick_d;
  logic                  bmc_q, bmc_d;
  logic                  tx_active_q, tx_active_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic [LFSR_WIDTH-1:0] step_next_s;
  logic                  step_bit_s;
  logic [15:0]           bit_cnt_inc_s;

  lfsr_galois_step u_step (
    .state_i      (lfsr_q),
    .polynomial_i (poly_q),
    .next_state_o (step_next_s),
    .out_bit_o    (step_bit_s)
  );

  assign bit_cnt_inc_s = bit_cnt_q + 16'd1;

  // Next-state, counter and line-level logic for the transmit sequence
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    poly_d      = poly_q;
    seek_cnt_d  = seek_cnt_q;
    num_bits_d  = num_bits_q;
    bit_cnt_d   = bit_cnt_q;
    tick_d      = tick_q;
    bmc_d       = bmc_q;
    tx_active_d = tx_active_q;
    done_d      = 1'b0;
    error_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // A zero mask or zero length would lock the LFSR or send nothing
          if ((polynomial == 17'd0) || (num_bits == 16'd0)) begin
            error_d = 1'b1;
          end else begin
            poly_d     = polynomial;
            num_bits_d = num_bits;
            seek_cnt_d = offset;
            lfsr_d     = LFSR_SEED;
            bit_cnt_d  = 16'd0;
            tick_d     = 8'd0;
            state_d    = SEEK;
          end
        end else begin
          state_d = IDLE;
        end
      end

      SEEK: begin
        if (seek_cnt_q != 17'd0) begin
          lfsr_d     = step_next_s;
          seek_cnt_d = seek_cnt_q - 17'd1;
        end else begin
          state_d     = FIRST_HALF;
          bmc_d       = ~bmc_q;
          tx_active_d = 1'b1;
          tick_d      = 8'd0;
        end
      end

      FIRST_HALF: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = 8'd0;
          state_d = SECOND_HALF;
          bmc_d   = bmc_q ^ step_bit_s;
        end else begin
          tick_d = tick_q + 8'd1;
        end
      end

      SECOND_HALF: begin
        if (tick_q == TICK_LAST) begin
          tick_d    = 8'd0;
          lfsr_d    = step_next_s;
          bit_cnt_d = bit_cnt_inc_s;
          if (bit_cnt_inc_s == num_bits_q) begin
            state_d     = DONE;
            bmc_d       = BMC_IDLE_LEVEL;
            tx_active_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            state_d = FIRST_HALF;
            bmc_d   = ~bmc_q;
          end
        end else begin
          tick_d = tick_q + 8'd1;
        end
      end

      DONE: begin
        state_d     = IDLE;
        bmc_d       = BMC_IDLE_LEVEL;
        tx_active_d = 1'b0;
      end

      default: begin
        state_d     = IDLE;
        bmc_d       = BMC_IDLE_LEVEL;
        tx_active_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset takes priority over any request
  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      state_q     <= IDLE;
      lfsr_q      <= LFSR_SEED;
      poly_q      <= 17'd0;
      seek_cnt_q  <= 17'd0;
      num_bits_q  <= 16'd0;
      bit_cnt_q   <= 16'd0;
      tick_q      <= 8'd0;
      bmc_q       <= BMC_IDLE_LEVEL;
      tx_active_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      poly_q      <= poly_d;
      seek_cnt_q  <= seek_cnt_d;
      num_bits_q  <= num_bits_d;
      bit_cnt_q   <= bit_cnt_d;
      tick_q      <= tick_d;
      bmc_q       <= bmc_d;
      tx_active_q <= tx_active_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bmc_out   = bmc_q;
  assign tx_active = tx_active_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_lfsr_bmc_transmitter.sv
// Directed self-checking bench for lfsr_bmc_transmitter (HALF_BIT_TICKS = 8).
module tb_lfsr_bmc_transmitter;

  logic        clk_96MHz;
  logic        reset;
  logic        start;
  logic [16:0] polynomial;
  logic [16:0] offset;
  logic [15:0] num_bits;
  logic        bmc_out;
  logic        tx_active;
  logic        busy;
  logic        done;
  logic        error;

  int compared   = 0;
  int mismatched = 0;
  bit exp_q[$];

  lfsr_bmc_transmitter #(
    .HALF_BIT_TICKS (8),
    .LFSR_SEED      (17'h00001)
  ) dut (
    .clk_96MHz  (clk_96MHz),
    .reset      (reset),
    .start      (start),
    .polynomial (polynomial),
    .offset     (offset),
    .num_bits   (num_bits),
    .bmc_out    (bmc_out),
    .tx_active  (tx_active),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clk_96MHz = 1'b0;
  always #5 clk_96MHz = ~clk_96MHz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_run(input bit lvl, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(lvl);
  endtask

  // Bits 1,0,0,0 from seed 1 with mask 1D258
  task automatic build_basic();
    exp_q.delete();
    push_run(1'b1, 8);
    push_run(1'b0, 8);
    push_run(1'b1, 16);
    push_run(1'b0, 16);
    push_run(1'b1, 16);
  endtask

  // Called at a negedge; returns at the negedge of the cycle after acceptance
  task automatic send(input logic [16:0] p, input logic [16:0] o, input logic [15:0] n);
    polynomial = p;
    offset     = o;
    num_bits   = n;
    start      = 1'b1;
    @(negedge clk_96MHz);
    start      = 1'b0;
  endtask

  task automatic check_seek(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check("seek_bmc", 32'(bmc_out), 32'd0);
      check("seek_busy", 32'(busy), 32'd1);
      check("seek_tx", 32'(tx_active), 32'd0);
      @(negedge clk_96MHz);
    end
  endtask

  task automatic check_wave(input int n, input int inject_at);
    for (int i = 0; i < n; i++) begin
      check($sformatf("wave_bmc[%0d]", i), 32'(bmc_out), 32'(exp_q[i]));
      check("wave_tx", 32'(tx_active), 32'd1);
      check("wave_busy", 32'(busy), 32'd1);
      check("wave_done", 32'(done), 32'd0);
      check("wave_err", 32'(error), 32'd0);
      if (i == inject_at) begin
        polynomial = 17'h00003;
        offset     = 17'd5;
        num_bits   = 16'd9;
        start      = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk_96MHz);
    end
    start = 1'b0;
  endtask

  task automatic check_done();
    check("done_pulse", 32'(done), 32'd1);
    check("done_bmc", 32'(bmc_out), 32'd0);
    check("done_tx", 32'(tx_active), 32'd0);
    check("done_busy", 32'(busy), 32'd1);
    @(negedge clk_96MHz);
    check("post_done", 32'(done), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_bmc", 32'(bmc_out), 32'd0);
    check("post_err", 32'(error), 32'd0);
  endtask

  task automatic reject(input logic [16:0] p, input logic [15:0] n);
    send(p, 17'd0, n);
    check("rej_err", 32'(error), 32'd1);
    check("rej_busy", 32'(busy), 32'd0);
    check("rej_bmc", 32'(bmc_out), 32'd0);
    @(negedge clk_96MHz);
    check("rej_err_clr", 32'(error), 32'd0);
    check("rej_busy2", 32'(busy), 32'd0);
    check("rej_bmc2", 32'(bmc_out), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    polynomial = 17'd0;
    offset     = 17'd0;
    num_bits   = 16'd0;
    repeat (3) @(negedge clk_96MHz);
    check("rst_bmc", 32'(bmc_out), 32'd0);
    check("rst_tx", 32'(tx_active), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(error), 32'd0);
    reset = 1'b0;
    @(negedge clk_96MHz);

    // Basic sequence: first toggle two cycles after acceptance
    build_basic();
    send(17'h1D258, 17'd0, 16'd4);
    check_seek(1);
    check_wave(exp_q.size(), -1);
    check_done();

    // Offset 2: start from lfsr 0E92C, bits 0,0
    exp_q.delete();
    push_run(1'b1, 16);
    push_run(1'b0, 16);
    send(17'h1D258, 17'd2, 16'd2);
    check_seek(3);
    check_wave(exp_q.size(), -1);
    check_done();

    // Rejected requests
    reject(17'h00000, 16'd4);
    reject(17'h1D258, 16'd0);

    // Second start during FIRST_HALF must be ignored
    build_basic();
    send(17'h1D258, 17'd0, 16'd4);
    check_seek(1);
    check_wave(exp_q.size(), 3);
    check_done();

    // Reset during the second bit
    build_basic();
    send(17'h1D258, 17'd0, 16'd4);
    check_seek(1);
    check_wave(20, -1);
    reset = 1'b1;
    @(negedge clk_96MHz);
    reset = 1'b0;
    check("rst_mid_bmc", 32'(bmc_out), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_tx", 32'(tx_active), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_96MHz);
      check("rst_quiet_done", 32'(done), 32'd0);
      check("rst_quiet_bmc", 32'(bmc_out), 32'd0);
    end

    // Restart after reset reproduces the basic waveform
    send(17'h1D258, 17'd0, 16'd4);
    check_seek(1);
    check_wave(exp_q.size(), -1);
    check_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
